// File: rtl/key_flag_gen.sv
// Two-button front end: synchronise and debounce active-low keys, then emit one
// arbitrated single-cycle flag per accepted press plus the debounced key levels.
module key_flag_gen #(
    parameter int unsigned CNT_DB = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key1_n,
    input  logic       key2_n,
    output logic       flag1,
    output logic       flag2,
    output logic [1:0] key_state
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StPressF = 2'b01,
        StDown   = 2'b10,
        StRelF   = 2'b11
    } key_st_e;

    localparam logic [23:0] CntMax = 24'(CNT_DB - 1);

    // Both synchroniser stages reset to released so a held key is seen as a fresh press.
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {key2_n, key1_n};
            sync2_q <= sync1_q;
        end
    end

    logic [1:0] press;
    logic [1:0] held_d;

    for (genvar i = 0; i < 2; i++) begin : g_key
        logic    s;
        key_st_e state_q, state_d;
        logic [23:0] cnt_q, cnt_d;
        logic    press_k;

        assign s = sync2_q[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_k = 1'b0;
            case (state_q)
                StIdle: begin
                    if (!s) begin
                        state_d = StPressF;
                        cnt_d   = '0;
                    end
                end
                StPressF: begin
                    if (s) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q < CntMax) begin
                        cnt_d = cnt_q + 24'd1;
                    end else begin
                        state_d = StDown;
                        cnt_d   = '0;
                        press_k = 1'b1;
                    end
                end
                StDown: begin
                    if (s) begin
                        state_d = StRelF;
                        cnt_d   = '0;
                    end
                end
                StRelF: begin
                    if (!s) begin
                        state_d = StDown;
                        cnt_d   = '0;
                    end else if (cnt_q < CntMax) begin
                        cnt_d = cnt_q + 24'd1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        assign press[i]  = press_k;
        assign held_d[i] = (state_d == StDown) || (state_d == StRelF);
    end

    logic       flag1_q;
    logic       flag2_q;
    logic [1:0] key_state_q;

    // Key1 wins a same-cycle tie; the losing key2 press is dropped, not retried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag1_q     <= 1'b0;
            flag2_q     <= 1'b0;
            key_state_q <= 2'b00;
        end else begin
            flag1_q     <= press[0];
            flag2_q     <= press[1] & ~press[0];
            key_state_q <= held_d;
        end
    end

    assign flag1     = flag1_q;
    assign flag2     = flag2_q;
    assign key_state = key_state_q;

endmodule
